// File: rtl/fetch_unit_ras_pkg.sv
// fetch_pkg: shared types and the next-PC priority decoder for fetch_unit_ras.
//   npc_sel_t  - source of the next PC (incrementor, branch target, RAS top, hold)
//   npc_dec_t  - decoded selection plus RAS push/pop strobes and underflow event
//   npc_decode - fixed-priority decode: stall > ret > call > jmp > taken branch > inc
package fetch_pkg;

    typedef enum logic [1:0] {
        NPC_INC  = 2'd0,
        NPC_TGT  = 2'd1,
        NPC_RAS  = 2'd2,
        NPC_HOLD = 2'd3
    } npc_sel_t;

    typedef struct packed {
        npc_sel_t sel;
        logic     push;
        logic     pop;
        logic     unf;
    } npc_dec_t;

    // A return on an empty stack falls through to pc_inc and only raises
    // the underflow event; it never pops, so the stack state stays consistent.
    function automatic npc_dec_t npc_decode(
        input logic stall,
        input logic ret,
        input logic call,
        input logic jmp,
        input logic br,
        input logic zero,
        input logic ras_empty
    );
        npc_dec_t d;
        d.sel  = NPC_INC;
        d.push = 1'b0;
        d.pop  = 1'b0;
        d.unf  = 1'b0;
        if (stall) begin
            d.sel = NPC_HOLD;
        end else if (ret) begin
            if (ras_empty) begin
                d.sel = NPC_INC;
                d.unf = 1'b1;
            end else begin
                d.sel = NPC_RAS;
                d.pop = 1'b1;
            end
        end else if (call) begin
            d.sel  = NPC_TGT;
            d.push = 1'b1;
        end else if (jmp || (br && zero)) begin
            d.sel = NPC_TGT;
        end else begin
            d.sel = NPC_INC;
        end
        return d;
    endfunction

endpackage

// File: rtl/fetch_unit_ras_stack.sv
// ras_stack: circular return-address stack.
//   clk        - clock (rising edge)
//   clear      - synchronous clear: empties the stack
//   push/pop   - one operation per cycle; push wins if both are asserted
//   push_data  - address to push
//   top        - entry at the top of the stack (only meaningful when !empty)
//   count      - number of valid entries, saturating at DEPTH
//   full/empty - count == DEPTH / count == 0
// Pushing while full overwrites the oldest entry: the top pointer simply
// advances onto the slot holding the oldest address.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                           clk,
    input  logic                           clear,
    input  logic                           push,
    input  logic                           pop,
    input  logic [W-1:0]                   push_data,
    output logic [W-1:0]                   top,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] top_r;
    logic [PTR_W-1:0] top_inc_s;
    logic [PTR_W-1:0] top_dec_s;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;

    // Modulo-DEPTH pointer neighbours (DEPTH need not be a power of two).
    always_comb begin
        top_inc_s = '0;
        top_dec_s = '0;
        if (top_r == PTR_W'(DEPTH - 1)) begin
            top_inc_s = '0;
        end else begin
            top_inc_s = top_r + PTR_W'(1);
        end
        if (top_r == '0) begin
            top_dec_s = PTR_W'(DEPTH - 1);
        end else begin
            top_dec_s = top_r - PTR_W'(1);
        end
    end

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == '0);

    // Top pointer and occupancy count.
    always_ff @(posedge clk) begin
        if (clear) begin
            top_r   <= '0;
            count_r <= '0;
        end else if (push) begin
            top_r <= top_inc_s;
            if (!full_s) begin
                count_r <= count_r + CNT_W'(1);
            end
        end else if (pop && !empty_s) begin
            top_r   <= top_dec_s;
            count_r <= count_r - CNT_W'(1);
        end
    end

    // Entry storage; contents past count are never read, so no clear needed.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_r[top_inc_s] <= push_data;
        end
    end

    assign top   = mem_r[top_r];
    assign count = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/fetch_unit_ras.sv
// fetch_unit_ras: instruction-fetch PC unit with return-address stack.
//   CLK        - clock, all state on rising edge
//   reset_ctrl - synchronous active-high reset (PC=RESET_PC, stack empty, flags 0)
//   stall_ctrl - hold PC, stack and flags
//   dst_in     - target offset (low OFF_W bits of a branch/jump/call target)
//   br_ctrl    - conditional branch, taken when zero_ctrl is high
//   zero_ctrl  - ALU zero line
//   jmp_ctrl   - unconditional jump
//   call_ctrl  - jump and push the return address (pc + 1)
//   ret_ctrl   - pop return address into PC
//   instr_addr - current PC (registered)
//   ras_count  - valid stack entries
//   ras_ovf    - sticky: push while full
//   ras_unf    - sticky: return while empty
import fetch_pkg::*;

module fetch_unit_ras #(
    parameter int ADDR_W    = 16,
    parameter int OFF_W     = 8,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic                             CLK,
    input  logic                             reset_ctrl,
    input  logic                             stall_ctrl,
    input  logic [OFF_W-1:0]                 dst_in,
    input  logic                             br_ctrl,
    input  logic                             zero_ctrl,
    input  logic                             jmp_ctrl,
    input  logic                             call_ctrl,
    input  logic                             ret_ctrl,
    output logic [ADDR_W-1:0]                instr_addr,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_ovf,
    output logic                             ras_unf
);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] ras_top_s;
    logic              ras_full_s;
    logic              ras_empty_s;
    logic              ovf_r;
    logic              unf_r;
    npc_dec_t          dec_s;

    // The target page comes from pc_inc, so a jump from the last word of a
    // page lands in the following page.
    assign pc_inc_s = pc_r + ADDR_W'(1);
    assign target_s = {pc_inc_s[ADDR_W-1:OFF_W], dst_in};

    // Priority decode and next-PC mux.
    always_comb begin
        dec_s = npc_decode(stall_ctrl, ret_ctrl, call_ctrl, jmp_ctrl,
                           br_ctrl, zero_ctrl, ras_empty_s);
        case (dec_s.sel)
            NPC_INC:  pc_next_s = pc_inc_s;
            NPC_TGT:  pc_next_s = target_s;
            NPC_RAS:  pc_next_s = ras_top_s;
            NPC_HOLD: pc_next_s = pc_r;
            default:  pc_next_s = pc_r;
        endcase
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (CLK),
        .clear     (reset_ctrl),
        .push      (dec_s.push),
        .pop       (dec_s.pop),
        .push_data (pc_inc_s),
        .top       (ras_top_s),
        .count     (ras_count),
        .full      (ras_full_s),
        .empty     (ras_empty_s)
    );

    // PC register and sticky stack-fault flags.
    always_ff @(posedge CLK) begin
        if (reset_ctrl) begin
            pc_r  <= ADDR_W'(RESET_PC);
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            pc_r <= pc_next_s;
            if (dec_s.push && ras_full_s) begin
                ovf_r <= 1'b1;
            end
            if (dec_s.unf) begin
                unf_r <= 1'b1;
            end
        end
    end

    assign instr_addr = pc_r;
    assign ras_ovf    = ovf_r;
    assign ras_unf    = unf_r;

endmodule

// File: tb/tb_fetch_unit_ras.sv
module tb_fetch_unit_ras;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        reset_ctrl = 1'b0;
    logic        stall_ctrl = 1'b0;
    logic [7:0]  dst_in = 8'd0;
    logic        br_ctrl = 1'b0;
    logic        zero_ctrl = 1'b0;
    logic        jmp_ctrl = 1'b0;
    logic        call_ctrl = 1'b0;
    logic        ret_ctrl = 1'b0;
    logic [15:0] instr_addr;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_unf;

    fetch_unit_ras dut (
        .CLK        (CLK),
        .reset_ctrl (reset_ctrl),
        .stall_ctrl (stall_ctrl),
        .dst_in     (dst_in),
        .br_ctrl    (br_ctrl),
        .zero_ctrl  (zero_ctrl),
        .jmp_ctrl   (jmp_ctrl),
        .call_ctrl  (call_ctrl),
        .ret_ctrl   (ret_ctrl),
        .instr_addr (instr_addr),
        .ras_count  (ras_count),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int pc;
        int cnt;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: PC as an integer, stack as a queue (back = newest).
    int   m_pc  = 0;
    int   m_stk[$];
    bit   m_ovf = 1'b0;
    bit   m_unf = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's controls, advance the model, push the expectation.
    task automatic step(input bit rst, input bit st, input bit ret, input bit call,
                        input bit jmp, input bit br, input bit zero, input int dst);
        int   inc;
        int   tgt;
        exp_t e;
        @(negedge CLK);
        reset_ctrl = rst;
        stall_ctrl = st;
        ret_ctrl   = ret;
        call_ctrl  = call;
        jmp_ctrl   = jmp;
        br_ctrl    = br;
        zero_ctrl  = zero;
        dst_in     = 8'(dst);
        if (rst) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!st) begin
            inc = (m_pc + 1) % 65536;
            tgt = (inc & 32'hFF00) | (dst & 32'hFF);
            if (ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin
                    m_pc  = inc;
                    m_unf = 1'b1;
                end
            end else if (call) begin
                m_stk.push_back(inc);
                if (m_stk.size() > DEPTH) begin
                    void'(m_stk.pop_front());
                    m_ovf = 1'b1;
                end
                m_pc = tgt;
            end else if (jmp || (br && zero)) begin
                m_pc = tgt;
            end else begin
                m_pc = inc;
            end
        end
        e.pc  = m_pc;
        e.cnt = m_stk.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
        sb_q.push_back(e);
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: the PC unit presents a new state after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("instr_addr", int'(instr_addr), e.pc);
                check("ras_count", int'(ras_count), e.cnt);
                check("ras_ovf", int'(ras_ovf), int'(e.ovf));
                check("ras_unf", int'(ras_unf), int'(e.unf));
            end
        end
    end

    initial begin
        // Reset then free-running increment.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        free_run(3);

        // Walk to 0x12FF with page-advancing jumps, then jump with offset 0x40.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 19; i++) step(0, 0, 0, 0, 1, 0, 0, 8'hFF);
        step(0, 0, 0, 0, 1, 0, 0, 8'h40);

        // Branch not taken / taken at 0x0010.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        free_run(16);
        step(0, 0, 0, 0, 0, 1, 0, 8'h80);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        free_run(16);
        step(0, 0, 0, 0, 0, 1, 1, 8'h80);

        // Call at 0x0005 to 0x20, step, return to 0x0006.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        free_run(5);
        step(0, 0, 0, 1, 0, 0, 0, 8'h20);
        free_run(1);
        step(0, 0, 1, 0, 0, 0, 0, 0);

        // Five nested calls into a four-entry stack, then six returns.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0, 8'h10 * (i + 1));
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0, 0, 0, 0);

        // ret and call together: ret wins, no push.
        step(0, 0, 1, 1, 0, 0, 0, 8'h33);

        // Stall with call held for 3 cycles, then reset mid-chain.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, 8'h50 + i);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, 1, 1, 8'hAA);
        step(1, 0, 0, 1, 0, 0, 0, 8'h11);
        step(0, 0, 1, 0, 0, 0, 0, 0);

        // PC wrap FFFF -> 0000.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) step(0, 0, 0, 0, 1, 0, 0, 8'hFF);
        free_run(2);

        // Randomized controls.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));
        end

        step(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
